// File: rtl/packet_receiver.sv
// packet_receiver
//
// Reassembles three-flit packets (DATA, CONTROL, RESPONSE) from an upstream
// valid/ready flit stream and presents each one downstream as a single
// 24-bit word over a pkt_valid/pkt_ready handshake. Protocol violations
// raise a one-cycle err_pulse with a sticky err_code. After a violation, the
// rest of the offending packet is discarded up to its eop flit.
//
// Optional feature: define PKT_RX_STATS_EN to build the saturating
// delivered-packet and error counters. Without it, both counters read 0
// and clear_stats has no effect.
//
// Ports
//   clk, reset            clock; synchronous active-high reset
//   valid / ready         upstream flit handshake
//   dest_addr             flit destination (taken from the DATA flit)
//   packet_type           00 DATA, 01 CONTROL, 10 RESPONSE, 11 RESERVED
//   payload               flit data byte
//   eop                   last flit of the packet
//   pkt_valid / pkt_ready downstream packet handshake
//   pkt_dest, pkt_data    assembled packet {RESPONSE, CONTROL, DATA}
//   err_pulse, err_code   error strobe; cause 01 bad type, 10 bad eop
//   clear_stats           synchronous clear of both counters
//   pkt_count, err_count  delivered packets / detected errors
module packet_receiver #(
  parameter int PKT_CNT_W = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  output logic                 ready,
  input  logic [1:0]           dest_addr,
  input  logic [1:0]           packet_type,
  input  logic [7:0]           payload,
  input  logic                 eop,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [1:0]           pkt_dest,
  output logic [23:0]          pkt_data,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  input  logic                 clear_stats,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE,
    EXP_CTRL,
    EXP_RESP,
    HOLD,
    DROP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic       deliver;
  logic [1:0] exp_type;
  logic       eop_bad;
  logic       err_det;
  logic [1:0] err_cause;
  logic       cap_data;
  logic       cap_ctrl;
  logic       cap_resp;

  assign accept    = valid && ready;
  assign pkt_valid = (state == HOLD);
  assign deliver   = pkt_valid && pkt_ready;

  // Next-state and flit classification. A wrong or reserved type takes
  // precedence over a misplaced eop when both apply to the same flit.
  always_comb begin
    next_state = state;
    exp_type   = 2'b00;
    eop_bad    = 1'b0;
    err_det    = 1'b0;
    err_cause  = 2'b00;
    cap_data   = 1'b0;
    cap_ctrl   = 1'b0;
    cap_resp   = 1'b0;

    case (state)
      IDLE: begin
        exp_type = 2'b00;
        eop_bad  = eop;
      end
      EXP_CTRL: begin
        exp_type = 2'b01;
        eop_bad  = eop;
      end
      EXP_RESP: begin
        exp_type = 2'b10;
        eop_bad  = !eop;
      end
      default: begin
        exp_type = 2'b00;
        eop_bad  = 1'b0;
      end
    endcase

    case (state)
      IDLE, EXP_CTRL, EXP_RESP: begin
        if (accept) begin
          if (packet_type != exp_type) begin
            err_det   = 1'b1;
            err_cause = 2'b01;
          end else if (eop_bad) begin
            err_det   = 1'b1;
            err_cause = 2'b10;
          end

          if (err_det) begin
            // An error on the eop flit ends the packet; otherwise skip the rest.
            next_state = eop ? IDLE : DROP;
          end else begin
            case (state)
              IDLE: begin
                cap_data   = 1'b1;
                next_state = EXP_CTRL;
              end
              EXP_CTRL: begin
                cap_ctrl   = 1'b1;
                next_state = EXP_RESP;
              end
              default: begin
                cap_resp   = 1'b1;
                next_state = HOLD;
              end
            endcase
          end
        end
      end
      HOLD: begin
        if (pkt_ready) next_state = IDLE;
      end
      DROP: begin
        if (accept && eop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // ready is registered from next_state so it never depends combinationally
  // on valid, and so it stays low while reset is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b0;
      pkt_dest  <= 2'b00;
      pkt_data  <= 24'h000000;
      err_pulse <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= next_state;
      ready     <= (next_state != HOLD);
      err_pulse <= err_det;
      if (err_det) err_code <= err_cause;
      if (cap_data) begin
        pkt_data[7:0] <= payload;
        pkt_dest      <= dest_addr;
      end
      if (cap_ctrl) pkt_data[15:8]  <= payload;
      if (cap_resp) pkt_data[23:16] <= payload;
    end
  end

`ifdef PKT_RX_STATS_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Saturating counters; clear_stats overrides a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (deliver && (pkt_cnt_q != '1)) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (err_det && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`else
  logic stats_unused;

  assign stats_unused = clear_stats ^ deliver;
  assign pkt_count    = '0;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_packet_receiver.sv
// tb_packet_receiver
//
// Drives directed packets followed by randomized flit traffic into
// packet_receiver. Every cycle, the outputs are compared with a behavioural
// model that tracks how many flits of the current packet have been
// collected, whether a bad packet is being skipped, and whether an
// assembled packet is waiting for the consumer.
module tb_packet_receiver;

  localparam int PKT_CNT_W = 16;
  localparam int ERR_CNT_W = 8;
  localparam int PKT_MAX   = (1 << PKT_CNT_W) - 1;
  localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;
`ifdef PKT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  logic                 valid;
  logic                 ready;
  logic [1:0]           dest_addr;
  logic [1:0]           packet_type;
  logic [7:0]           payload;
  logic                 eop;
  logic                 pkt_valid;
  logic                 pkt_ready;
  logic [1:0]           pkt_dest;
  logic [23:0]          pkt_data;
  logic                 err_pulse;
  logic [1:0]           err_code;
  logic                 clear_stats;
  logic [PKT_CNT_W-1:0] pkt_count;
  logic [ERR_CNT_W-1:0] err_count;

  packet_receiver #(
    .PKT_CNT_W(PKT_CNT_W),
    .ERR_CNT_W(ERR_CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .ready      (ready),
    .dest_addr  (dest_addr),
    .packet_type(packet_type),
    .payload    (payload),
    .eop        (eop),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_data   (pkt_data),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .clear_stats(clear_stats),
    .pkt_count  (pkt_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int check_count = 0;
  int fail_count  = 0;

  // Reference model state
  bit          m_ready;
  bit          m_pvalid;
  logic [1:0]  m_dest;
  logic [23:0] m_data;
  bit          m_err_pulse;
  logic [1:0]  m_err_code;
  int          m_pcount;
  int          m_ecount;
  int          m_n;
  bit          m_drop;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit v, input logic [1:0] t, input logic [1:0] d,
                           input logic [7:0] p, input bit e, input bit pr,
                           input bit cs, input bit rst);
    bit         acc;
    bit         err;
    logic [1:0] code;
    if (rst) begin
      m_ready = 0; m_pvalid = 0; m_dest = 2'b00; m_data = 24'h0;
      m_err_pulse = 0; m_err_code = 2'b00; m_pcount = 0; m_ecount = 0;
      m_n = 0; m_drop = 0;
      return;
    end
    acc  = v && m_ready;
    err  = 0;
    code = 2'b00;
    m_err_pulse = 0;
    if (m_pvalid) begin
      if (pr) begin
        m_pvalid = 0;
        if (m_pcount < PKT_MAX) m_pcount++;
      end
    end else if (acc) begin
      if (m_drop) begin
        if (e) m_drop = 0;
      end else begin
        if (int'(t) != m_n) begin
          err = 1; code = 2'b01;
        end else if ((m_n < 2) ? e : !e) begin
          err = 1; code = 2'b10;
        end else begin
          m_data[8*m_n +: 8] = p;
          if (m_n == 0) m_dest = d;
          m_n++;
          if (m_n == 3) begin
            m_pvalid = 1;
            m_n = 0;
          end
        end
        if (err) begin
          m_err_pulse = 1;
          m_err_code  = code;
          if (m_ecount < ERR_MAX) m_ecount++;
          m_n    = 0;
          m_drop = !e;
        end
      end
    end
    if (cs) begin
      m_pcount = 0;
      m_ecount = 0;
    end
    if (!STATS) begin
      m_pcount = 0;
      m_ecount = 0;
    end
    m_ready = !m_pvalid;
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] t, input logic [1:0] d,
                               input logic [7:0] p, input bit e, input bit pr,
                               input bit cs, input bit rst);
    valid = v; packet_type = t; dest_addr = d; payload = p; eop = e;
    pkt_ready = pr; clear_stats = cs; reset = rst;
    @(posedge clk);
    modelStep(v, t, d, p, e, pr, cs, rst);
    #1;
    checkOutput("ready", 32'(ready), 32'(m_ready));
    checkOutput("pkt_valid", 32'(pkt_valid), 32'(m_pvalid));
    checkOutput("err_pulse", 32'(err_pulse), 32'(m_err_pulse));
    checkOutput("err_code", 32'(err_code), 32'(m_err_code));
    checkOutput("pkt_count", 32'(pkt_count), 32'(m_pcount));
    checkOutput("err_count", 32'(err_count), 32'(m_ecount));
    if (m_pvalid || rst) begin
      checkOutput("pkt_data", 32'(pkt_data), 32'(m_data));
      checkOutput("pkt_dest", 32'(pkt_dest), 32'(m_dest));
    end
  endtask

  task automatic flit(input logic [1:0] t, input logic [1:0] d, input logic [7:0] p,
                      input bit e);
    applyStimulus(1'b1, t, d, p, e, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit pr, input bit cs);
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 1'b0, pr, cs, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'b00, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    valid = 0; packet_type = 0; dest_addr = 0; payload = 0; eop = 0;
    pkt_ready = 0; clear_stats = 0; reset = 1;

    doReset();
    doReset();
    checkOutput("reset_ready", 32'(ready), 32'd0);
    idle(1'b0, 1'b0);
    checkOutput("post_reset_ready", 32'(ready), 32'd1);

    // Basic packet, consumer always ready
    flit(2'b00, 2'd1, 8'h11, 1'b0);
    flit(2'b01, 2'd0, 8'h22, 1'b0);
    flit(2'b10, 2'd0, 8'h33, 1'b1);
    checkOutput("basic_data", 32'(pkt_data), 32'h332211);
    checkOutput("basic_dest", 32'(pkt_dest), 32'd1);
    checkOutput("basic_valid", 32'(pkt_valid), 32'd1);
    idle(1'b1, 1'b0);
    checkOutput("basic_count", 32'(pkt_count), STATS ? 32'd1 : 32'd0);

    // Consumer stalls for 5 cycles
    flit(2'b00, 2'd2, 8'h44, 1'b0);
    flit(2'b01, 2'd0, 8'h55, 1'b0);
    flit(2'b10, 2'd0, 8'h66, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b00, 2'd3, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // CONTROL in IDLE, then skipped flits up to eop, then a good packet
    flit(2'b01, 2'd0, 8'hA0, 1'b0);
    checkOutput("ctrl_first_code", 32'(err_code), 32'd1);
    flit(2'b00, 2'd0, 8'hA1, 1'b0);
    flit(2'b10, 2'd0, 8'hA2, 1'b0);
    flit(2'b11, 2'd0, 8'hA3, 1'b1);
    flit(2'b00, 2'd3, 8'h01, 1'b0);
    flit(2'b01, 2'd0, 8'h02, 1'b0);
    flit(2'b10, 2'd0, 8'h03, 1'b1);
    idle(1'b1, 1'b0);

    // Repeated DATA-with-eop errors saturate the error counter
    for (int i = 0; i < 300; i++) flit(2'b00, 2'd0, 8'(i), 1'b1);
    checkOutput("err_sat", 32'(err_count), STATS ? 32'd255 : 32'd0);
    checkOutput("eop_err_code", 32'(err_code), 32'd2);

    // Reset in EXP_RESP, then in HOLD
    flit(2'b00, 2'd1, 8'h10, 1'b0);
    flit(2'b01, 2'd0, 8'h20, 1'b0);
    doReset();
    idle(1'b0, 1'b0);
    flit(2'b00, 2'd2, 8'h30, 1'b0);
    flit(2'b01, 2'd0, 8'h40, 1'b0);
    applyStimulus(1'b1, 2'b10, 2'd0, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    doReset();
    checkOutput("hold_reset_valid", 32'(pkt_valid), 32'd0);
    idle(1'b0, 1'b0);

    // clear_stats coinciding with a delivery
    flit(2'b00, 2'd1, 8'h61, 1'b0);
    flit(2'b01, 2'd0, 8'h62, 1'b0);
    flit(2'b10, 2'd0, 8'h63, 1'b1);
    idle(1'b1, 1'b1);
    checkOutput("clear_wins", 32'(pkt_count), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit         v, e, pr, cs, rst;
      logic [1:0] t;
      v   = ($urandom_range(0, 3) != 0);
      t   = ($urandom_range(0, 9) < 8) ? 2'(m_n) : 2'($urandom_range(0, 3));
      if (m_drop) e = ($urandom_range(0, 2) == 0);
      else        e = ($urandom_range(0, 9) < 8) ? (m_n == 2) : ($urandom_range(0, 1) == 1);
      pr  = ($urandom_range(0, 1) == 1);
      cs  = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 399) == 0);
      applyStimulus(v, t, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    e, pr, cs, rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
